// File: rtl/brick_scan_ctrl.sv
// Brick wall scan controller: walks one brick per clock through a shared
// combinational bounce detector, clears the first brick hit and reports it.
module brick_scan_ctrl #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int IDX_W    = 5,
    parameter int X0       = 40,
    parameter int Y0       = 40,
    parameter int PITCH_X  = 40,
    parameter int PITCH_Y  = 20,
    parameter int BRICK_RX = 18,
    parameter int BRICK_RY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_level,
    input  logic [9:0]       b_x,
    input  logic [9:0]       b_y,
    input  logic             det_bounced,
    input  logic [1:0]       det_direction,
    output logic [9:0]       det_b_x,
    output logic [9:0]       det_b_y,
    output logic [9:0]       det_w_x,
    output logic [9:0]       det_w_y,
    output logic [5:0]       det_w_rx,
    output logic [5:0]       det_w_ry,
    output logic             det_enable,
    output logic             busy,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_index,
    output logic [1:0]       hit_dir,
    output logic             done,
    output logic [IDX_W:0]   bricks_left,
    output logic             all_clear,
    output logic [1:0]       o_dbg_state
);

    localparam int              N        = COLS * ROWS;
    localparam int              COL_W    = $clog2(COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   N_BRICKS = (IDX_W + 1)'(N);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N-1:0]     r_alive;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_bricks_left;
    logic [IDX_W-1:0] r_hit_index;
    logic [1:0]       r_hit_dir;
    logic             r_hit_seen;
    logic [9:0]       r_bx;
    logic [9:0]       r_by;

    logic             w_accept;
    logic             w_take_hit;
    logic             w_step;
    logic             w_cur_alive;
    logic [COL_W-1:0] w_col;
    logic [IDX_W-1:0] w_row;

    assign w_cur_alive = r_alive[r_idx];
    assign w_col       = r_idx[COL_W-1:0];
    assign w_row       = r_idx >> COL_W;

    assign det_b_x     = r_bx;
    assign det_b_y     = r_by;
    assign det_w_x     = 10'(X0) + 10'(w_col) * 10'(PITCH_X);
    assign det_w_y     = 10'(Y0) + 10'(w_row) * 10'(PITCH_Y);
    assign det_w_rx    = 6'(BRICK_RX);
    assign det_w_ry    = 6'(BRICK_RY);
    assign det_enable  = (r_state == S_SCAN) && w_cur_alive;

    assign hit_index   = r_hit_index;
    assign hit_dir     = r_hit_dir;
    assign bricks_left = r_bricks_left;
    assign all_clear   = (r_bricks_left == '0);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // start is a single-cycle request honoured only in IDLE (no queueing);
    // load_level is a single-cycle command that wins over start in any state.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_take_hit   = 1'b0;
        w_step       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        hit_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy = 1'b1;
                if (det_bounced && w_cur_alive) begin
                    w_take_hit   = 1'b1;
                    w_state_next = S_REPORT;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = S_REPORT;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_REPORT: begin
                done         = 1'b1;
                hit_valid    = r_hit_seen;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (load_level) begin
            w_state_next = S_IDLE;
            w_accept     = 1'b0;
            w_take_hit   = 1'b0;
            w_step       = 1'b0;
        end
    end

    // Brick clear lands on the SCAN->REPORT edge so it is visible alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alive       <= '1;
            r_bricks_left <= N_BRICKS;
            r_idx         <= '0;
            r_hit_index   <= '0;
            r_hit_dir     <= '0;
            r_hit_seen    <= 1'b0;
            r_bx          <= '0;
            r_by          <= '0;
        end else if (load_level) begin
            r_alive       <= '1;
            r_bricks_left <= N_BRICKS;
            r_hit_seen    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bx       <= b_x;
                r_by       <= b_y;
                r_idx      <= '0;
                r_hit_seen <= 1'b0;
            end
            if (w_take_hit) begin
                r_alive[r_idx] <= 1'b0;
                r_bricks_left  <= r_bricks_left - CNT_ONE;
                r_hit_index    <= r_idx;
                r_hit_dir      <= det_direction;
                r_hit_seen     <= 1'b1;
            end
            if (w_step) begin
                r_idx <= r_idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_brick_scan_ctrl.sv
// Bench for brick_scan_ctrl: behavioural detector and scan model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_brick_scan_ctrl;

    localparam int N    = 32;
    localparam int COLS = 8;
    localparam int X0   = 40;
    localparam int Y0   = 40;
    localparam int PX   = 40;
    localparam int PY   = 20;
    localparam int RX   = 18;
    localparam int RY   = 8;
    localparam int BR   = 4;
    localparam logic [1:0] B_UP   = 2'd0;
    localparam logic [1:0] B_DOWN = 2'd1;

    logic       clk, rst;
    logic       start, load_level;
    logic [9:0] b_x, b_y;
    logic       det_bounced;
    logic [1:0] det_direction;
    logic [9:0] det_b_x, det_b_y, det_w_x, det_w_y;
    logic [5:0] det_w_rx, det_w_ry;
    logic       det_enable, busy, hit_valid, done, all_clear;
    logic [4:0] hit_index;
    logic [1:0] hit_dir;
    logic [5:0] bricks_left;
    logic [1:0] dbg_state;

    logic       start2, load_level2;
    logic [9:0] b_x2, b_y2;
    logic       det_bounced2;
    logic [1:0] det_direction2;
    logic [9:0] det_b_x2, det_b_y2, det_w_x2, det_w_y2;
    logic [5:0] det_w_rx2, det_w_ry2;
    logic       det_enable2, busy2, hit_valid2, done2, all_clear2;
    logic [0:0] hit_index2;
    logic [1:0] hit_dir2;
    logic [1:0] bricks_left2;
    logic [1:0] dbg_state2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Stand-in for bounce_detect with ball radius 4: overlap of the ball's
    // bounding box with the brick; ball above centre bounces up, else down.
    function automatic logic [2:0] detect(input logic en, input logic [9:0] bx, by, wx, wy,
                                          input logic [5:0] rx, ry);
        int dx, dy;
        logic hit;
        dx = int'(bx) - int'(wx);
        dy = int'(by) - int'(wy);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        hit = en && (dx <= int'(rx) + BR) && (dy <= int'(ry) + BR);
        return {hit, (by < wy) ? B_UP : B_DOWN};
    endfunction

    assign {det_bounced, det_direction} =
        detect(det_enable, det_b_x, det_b_y, det_w_x, det_w_y, det_w_rx, det_w_ry);
    assign {det_bounced2, det_direction2} =
        detect(det_enable2, det_b_x2, det_b_y2, det_w_x2, det_w_y2, det_w_rx2, det_w_ry2);

    brick_scan_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .load_level(load_level),
        .b_x(b_x), .b_y(b_y), .det_bounced(det_bounced), .det_direction(det_direction),
        .det_b_x(det_b_x), .det_b_y(det_b_y), .det_w_x(det_w_x), .det_w_y(det_w_y),
        .det_w_rx(det_w_rx), .det_w_ry(det_w_ry), .det_enable(det_enable), .busy(busy),
        .hit_valid(hit_valid), .hit_index(hit_index), .hit_dir(hit_dir), .done(done),
        .bricks_left(bricks_left), .all_clear(all_clear), .o_dbg_state(dbg_state)
    );

    brick_scan_ctrl #(.COLS(2), .ROWS(1), .IDX_W(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .load_level(load_level2),
        .b_x(b_x2), .b_y(b_y2), .det_bounced(det_bounced2), .det_direction(det_direction2),
        .det_b_x(det_b_x2), .det_b_y(det_b_y2), .det_w_x(det_w_x2), .det_w_y(det_w_y2),
        .det_w_rx(det_w_rx2), .det_w_ry(det_w_ry2), .det_enable(det_enable2), .busy(busy2),
        .hit_valid(hit_valid2), .hit_index(hit_index2), .hit_dir(hit_dir2), .done(done2),
        .bricks_left(bricks_left2), .all_clear(all_clear2), .o_dbg_state(dbg_state2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cx(input int i);
        return X0 + (i % COLS) * PX;
    endfunction

    function automatic int cy(input int i);
        return Y0 + (i / COLS) * PY;
    endfunction

    // ---------------- reference model (main DUT) ----------------
    // Whole outcome of a scan is decided when it is accepted: the first alive
    // brick overlapping the latched ball, then it only counts down cycles.
    bit [N-1:0] m_alive;
    int         m_left, m_phase, m_len, m_pos, m_pend, m_hit_index;
    logic [1:0] m_pend_dir, m_hit_dir;
    bit         m_hit;
    logic [9:0] m_bx, m_by;
    logic [2:0] m_det;

    task automatic model_step();
        if (rst) begin
            m_alive = '1; m_left = N; m_phase = 0; m_pos = 0; m_len = 0;
            m_hit = 0; m_hit_index = 0; m_hit_dir = 0; m_bx = 0; m_by = 0;
        end else if (load_level) begin
            m_alive = '1; m_left = N; m_phase = 0; m_hit = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_bx = b_x; m_by = b_y; m_hit = 0; m_len = N; m_pos = 0; m_phase = 1;
                for (int i = N - 1; i >= 0; i--) begin
                    m_det = detect(m_alive[i], m_bx, m_by, 10'(cx(i)), 10'(cy(i)), 6'(RX), 6'(RY));
                    if (m_det[2]) begin
                        m_hit = 1; m_pend = i; m_pend_dir = m_det[1:0]; m_len = i + 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_pos++;
            if (m_pos == m_len) begin
                m_phase = 2;
                if (m_hit) begin
                    m_alive[m_pend] = 1'b0;
                    m_left--;
                    m_hit_index = m_pend;
                    m_hit_dir   = m_pend_dir;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- compare process ----------------
    task automatic compare();
        chk("busy", int'(busy), int'(m_phase == 1));
        chk("done", int'(done), int'(m_phase == 2));
        chk("hit_valid", int'(hit_valid), int'(m_phase == 2 && m_hit));
        chk("hit_index", int'(hit_index), m_hit_index);
        chk("hit_dir", int'(hit_dir), int'(m_hit_dir));
        chk("bricks_left", int'(bricks_left), m_left);
        chk("all_clear", int'(all_clear), int'(m_left == 0));
        chk("det_b_x", int'(det_b_x), int'(m_bx));
        chk("det_b_y", int'(det_b_y), int'(m_by));
        chk("det_enable", int'(det_enable), (m_phase == 1) ? int'(m_alive[m_pos]) : 0);
        if (m_phase == 1) begin
            chk("det_w_x", int'(det_w_x), cx(m_pos));
            chk("det_w_y", int'(det_w_y), cy(m_pos));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare();
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1 of "cycle 0"; returns at posedge+1 of the cycle after done.
    task automatic run_scan(input bit sel, input int bx, input int by,
                            output int dc, output int hv, output int hi, output int hd);
        dc = -1; hv = 0; hi = 0; hd = 0;
        if (sel) begin start2 = 1; b_x2 = 10'(bx); b_y2 = 10'(by); end
        else     begin start  = 1; b_x  = 10'(bx); b_y  = 10'(by); end
        @(posedge clk); #1;
        start = 0; start2 = 0;
        for (int c = 1; c < 200 && dc < 0; c++) begin
            @(negedge clk);
            if (sel ? done2 : done) begin
                dc = c;
                hv = sel ? int'(hit_valid2) : int'(hit_valid);
                hi = sel ? int'(hit_index2) : int'(hit_index);
                hd = sel ? int'(hit_dir2)   : int'(hit_dir);
            end
            @(posedge clk); #1;
        end
        if (dc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_timeout: no done within 200 cycles, required a done pulse");
        end
    endtask

    task automatic pulse_load();
        load_level = 1;
        @(posedge clk); #1;
        load_level = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dc, hv, hi, hd;
        bit saw;
        rst = 1; start = 0; load_level = 0; b_x = 0; b_y = 0;
        start2 = 0; load_level2 = 0; b_x2 = 0; b_y2 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;

        @(negedge clk);
        chk("rst_bricks_left", int'(bricks_left), 32);
        chk("rst_busy", int'(busy), 0);
        chk("rst_all_clear", int'(all_clear), 0);
        chk("rst_det_w_x", int'(det_w_x), 40);
        chk("rst_det_w_y", int'(det_w_y), 40);
        chk("rst_det_w_rx", int'(det_w_rx), 18);
        chk("rst_det_w_ry", int'(det_w_ry), 8);
        chk("rst_bricks_left2", int'(bricks_left2), 2);
        @(posedge clk); #1;

        run_scan(0, 240, 30, dc, hv, hi, hd);
        chk("s1_done_cycle", dc, 7);
        chk("s1_hit_valid", hv, 1);
        chk("s1_hit_index", hi, 5);
        chk("s1_hit_dir", hd, int'(B_UP));
        chk("s1_bricks_left", int'(bricks_left), 31);

        run_scan(0, 240, 30, dc, hv, hi, hd);
        chk("s2_done_cycle", dc, 33);
        chk("s2_hit_valid", hv, 0);
        chk("s2_bricks_left", int'(bricks_left), 31);

        pulse_load();
        run_scan(0, 220, 40, dc, hv, hi, hd);
        chk("s3_done_cycle", dc, 6);
        chk("s3_hit_valid", hv, 1);
        chk("s3_hit_index", hi, 4);
        chk("s3_hit_dir", hd, int'(B_DOWN));

        start = 1; b_x = 600; b_y = 600;
        @(posedge clk); #1;
        start = 0;
        repeat (9) begin @(posedge clk); #1; end
        load_level = 1;
        @(posedge clk); #1;
        load_level = 0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_bricks_left", int'(bricks_left), 32);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        chk("abort_no_done", int'(saw), 0);
        @(posedge clk); #1;

        run_scan(1, 40, 30, dc, hv, hi, hd);
        chk("small1_done_cycle", dc, 2);
        chk("small1_hit_index", hi, 0);
        chk("small1_hit_valid", hv, 1);
        run_scan(1, 80, 30, dc, hv, hi, hd);
        chk("small2_done_cycle", dc, 3);
        chk("small2_hit_index", hi, 1);
        chk("small2_bricks_left", int'(bricks_left2), 0);
        chk("small2_all_clear", int'(all_clear2), 1);
        run_scan(1, 40, 30, dc, hv, hi, hd);
        chk("small3_done_cycle", dc, 3);
        chk("small3_hit_valid", hv, 0);

        for (int k = 0; k < 4000; k++) begin
            start      = ($urandom_range(0, 5) == 0);
            load_level = (m_phase != 2) && ($urandom_range(0, 199) == 0);
            b_x        = 10'($urandom_range(0, 360));
            b_y        = 10'($urandom_range(0, 130));
            @(posedge clk); #1;
        end
        start = 0; load_level = 0;
        repeat (40) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/brick_scan_ctrl.md
# brick_scan_ctrl

Sequences a single shared `bounce_detect` instance across the brick wall, checking one brick per clock. Brick-alive state lives in this block. On a frame `start`, it latches the ball position and scans bricks in index order. It stops at the first collision, clears that brick, and reports the brick index and bounce direction to the ball/game logic. It sits between the game FSM and the shared detector; the detector stays purely combinational.

## Interface
- `COLS`, 8: bricks per row; must be a power of 2.
- `ROWS`, 4: brick rows.
- `IDX_W`, 5: index width, equal to clog2(COLS*ROWS).
- `X0`, 40: x center of column 0.
- `Y0`, 40: y center of row 0.
- `PITCH_X`, 40: x spacing between brick centers.
- `PITCH_Y`, 20: y spacing between brick centers.
- `BRICK_RX`, 18: brick half-width.
- `BRICK_RY`, 8: brick half-height.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to scan the wall for the current frame.
- `load_level` in 1: one-cycle request to set every brick alive.
- `b_x`, `b_y` in 10 each: ball center, sampled only on an accepted `start`.
- `det_bounced` in 1: from the detector's `bounced` output.
- `det_direction` in 2: from the detector's `direction` output, using the def.v codes B_UP/B_DOWN/B_LEFT/B_RIGHT.
- `det_b_x`, `det_b_y` out 10 each: latched ball position, driven to the detector.
- `det_w_x`, `det_w_y` out 10 each: center of the current candidate brick.
- `det_w_rx`, `det_w_ry` out 6 each: constant BRICK_RX and BRICK_RY.
- `det_enable` out 1: high only in SCAN while the current brick is alive.
- `busy` out 1: high while in SCAN.
- `hit_valid` out 1: one-cycle pulse when a collision is found.
- `hit_index` out IDX_W: index of the hit brick; holds until the next hit.
- `hit_dir` out 2: bounce direction of the hit; holds until the next hit.
- `done` out 1: one-cycle pulse when a scan completes.
- `bricks_left` out IDX_W+1: count of alive bricks.
- `all_clear` out 1: high when `bricks_left` is 0.

## Operation
- N = COLS*ROWS. Each brick has an `alive[N]` bit. Brick i has col = i[log2 COLS-1:0] and row = i >> log2(COLS).
- `det_w_x` = X0 + col*PITCH_X and `det_w_y` = Y0 + row*PITCH_Y. Both are computed from the registered index and truncated to 10 bits; parameters are chosen so no overflow occurs.
- States:
  - IDLE: `busy` = 0. An accepted `start` latches `b_x`/`b_y` into `det_b_x`/`det_b_y`, sets idx = 0, and moves to SCAN.
  - SCAN: the detector result for brick idx is sampled in the same cycle.
    - If `det_bounced` and `det_enable`: clear `alive[idx]`, decrement `bricks_left`, and register `hit_index` = idx and `hit_dir` = `det_direction`. Go to REPORT.
    - Else if idx == N-1: go to REPORT with no hit.
    - Else: idx++.
  - REPORT (one cycle): `done` = 1, and `hit_valid` = 1 if a hit was recorded. Return to IDLE.
- Only the first hit per scan is taken, so the lowest alive index wins when bricks overlap.
- Dead bricks are never reported, because `det_enable` is 0 for them.
- Precedence and boundary rules:
  - `load_level` beats `start`.
  - `load_level` in any state forces IDLE, sets all `alive` bits, sets `bricks_left` = N, and suppresses `hit_valid`/`done` for the aborted scan.
  - `start` while not in IDLE is ignored; there is no queueing.
  - `b_x`/`b_y` changes during a scan have no effect.
  - A scan with `bricks_left` == 0 still runs all N cycles and reports `done` with no hit.

## Timing
- Reset values: state IDLE, every `alive` bit 1, `bricks_left` = N, `all_clear` = 0, idx = 0.
- Other reset values: `busy`/`hit_valid`/`done`/`det_enable` = 0, `hit_index` = 0, `hit_dir` = 0, `det_b_x`/`det_b_y` = 0.
- Scan latency: `start` accepted at cycle 0 → brick i is evaluated at cycle 1+i.
  - Hit on brick i: `hit_valid` and `done` at cycle 2+i.
  - No hit: `done` at cycle N+1.
- `bricks_left`/`all_clear`/`alive` update at the REPORT cycle edge, so they are visible from the cycle with `done`.
- Back-to-back: a `start` in the cycle after `done` is accepted.

## Test plan
- Reset, then check outputs: `bricks_left` = 32, `busy` = 0, `all_clear` = 0, `det_w_x` = 40, `det_w_y` = 40.
- Bench instantiates `bounce_detect` with b_radius = 4. Ball (240,30), `start` at cycle 0 → `hit_valid` at cycle 7 with `hit_index` = 5, `hit_dir` = B_UP; `bricks_left` = 31.
- Repeat `start` with the same ball → no `hit_valid`, `done` at cycle 33; brick 5 stays dead.
- After `load_level`, ball (220,40) overlaps bricks 4 and 5 → `hit_index` = 4, `hit_dir` = B_DOWN, `done` at cycle 6.
- Pulse `load_level` at cycle 10 of a no-hit scan → `busy` = 0 next cycle, no `done`, `bricks_left` = 32.
- Set COLS = 2, ROWS = 1. Two scans, each hitting a different brick → `bricks_left` reaches 0 and `all_clear` = 1. A third scan gives `done` at cycle 3 with no hit.
